// File: rtl/condicionador_entradas.sv
`default_nettype none
// condicionador_entradas: synchronises and debounces the raw pushbuttons, then
// turns the clean colour levels into validated one-hot plays and a jogar pulse.
module condicionador_entradas #(
  parameter int DEBOUNCE_CICLOS = 50000,
  parameter int CW              = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_in,
  input  logic       jogar_in,
  output logic [3:0] botoes_limpos,
  output logic       jogar_pulso,
  output logic       jogada_pulso,
  output logic [3:0] jogada_codigo,
  output logic       multipla,
  output logic [1:0] db_estado
);

  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    LIVRE       = 2'd0,
    PRESSIONADO = 2'd1,
    INVALIDO    = 2'd2
  } estado_t;

  logic [4:0] raw_w;
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;
  logic [4:0] stable_w;

  assign raw_w = {jogar_in, botoes_in};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // Bit 4 is jogar, bits 3:0 are the colour buttons; each debounces on its own.
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          stable_q;
    logic          stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync2_q[i] != stable_q) begin
        if (cnt_q == CNT_FIM) begin
          stable_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_w[i] = stable_q;
  end

  logic jogar_prev_q;
  logic jogar_pulso_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogar_prev_q  <= 1'b0;
      jogar_pulso_q <= 1'b0;
    end else begin
      jogar_prev_q  <= stable_w[4];
      jogar_pulso_q <= stable_w[4] & ~jogar_prev_q;
    end
  end

  logic [3:0] s_w;
  logic [2:0] n_bot_w;
  estado_t    estado_q;
  logic       jogada_pulso_q;
  logic [3:0] codigo_q;
  logic       multipla_q;

  assign s_w     = stable_w[3:0];
  assign n_bot_w = 3'(s_w[0]) + 3'(s_w[1]) + 3'(s_w[2]) + 3'(s_w[3]);

  // A press is only accepted from LIVRE, so a held button never re-triggers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= LIVRE;
      jogada_pulso_q <= 1'b0;
      codigo_q       <= '0;
      multipla_q     <= 1'b0;
    end else begin
      jogada_pulso_q <= 1'b0;
      case (estado_q)
        LIVRE: begin
          if (n_bot_w == 3'd1) begin
            codigo_q       <= s_w;
            jogada_pulso_q <= 1'b1;
            estado_q       <= PRESSIONADO;
          end else if (n_bot_w >= 3'd2) begin
            estado_q   <= INVALIDO;
            multipla_q <= 1'b1;
          end
        end
        PRESSIONADO: begin
          if (s_w == 4'd0) begin
            estado_q <= LIVRE;
          end
        end
        INVALIDO: begin
          if (s_w == 4'd0) begin
            estado_q   <= LIVRE;
            multipla_q <= 1'b0;
          end
        end
        default: begin
          estado_q   <= LIVRE;
          multipla_q <= 1'b0;
        end
      endcase
    end
  end

  assign botoes_limpos = s_w;
  assign jogar_pulso   = jogar_pulso_q;
  assign jogada_pulso  = jogada_pulso_q;
  assign jogada_codigo = codigo_q;
  assign multipla      = multipla_q;
  assign db_estado     = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_condicionador_entradas.sv
`default_nettype none
// tb_condicionador_entradas: directed scenarios plus random button traffic,
// checked every cycle against a sliding-window debounce and play-rule model.
module tb_condicionador_entradas;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes_in = 4'd0;
  logic       jogar_in = 1'b0;
  logic [3:0] botoes_limpos;
  logic       jogar_pulso;
  logic       jogada_pulso;
  logic [3:0] jogada_codigo;
  logic       multipla;
  logic [1:0] db_estado;

  int checks = 0;
  int errors = 0;

  condicionador_entradas #(.DEBOUNCE_CICLOS(N), .CW(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_in    (botoes_in),
    .jogar_in     (jogar_in),
    .botoes_limpos(botoes_limpos),
    .jogar_pulso  (jogar_pulso),
    .jogada_pulso (jogada_pulso),
    .jogada_codigo(jogada_codigo),
    .multipla     (multipla),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  wire [12:0] dut_v = {botoes_limpos, jogar_pulso, jogada_pulso, jogada_codigo, multipla, db_estado};

  // Reference model: an input level is accepted once the last N synchronised
  // samples (raw samples 2..N+1 edges old) all disagree with the current level.
  logic [4:0] hist[$];
  logic [4:0] st_m, st_prev_m;
  logic [3:0] cod_m;
  logic       jp_m, pl_m, busy_m, inv_m, all_m;
  int         ones_m;

  task automatic model_clear();
    st_m = '0; st_prev_m = '0; cod_m = '0;
    jp_m = 1'b0; pl_m = 1'b0; busy_m = 1'b0; inv_m = 1'b0;
    hist = {};
    for (int j = 0; j < N + 2; j++) hist.push_back(5'd0);
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      hist.push_front({jogar_in, botoes_in});
      hist = hist[0:N+1];
      jp_m = st_m[4] & ~st_prev_m[4];
      st_prev_m = st_m;
      ones_m = $countones(st_m[3:0]);
      pl_m = 1'b0;
      if (!busy_m) begin
        if (ones_m == 1) begin
          pl_m = 1'b1; cod_m = st_m[3:0]; busy_m = 1'b1; inv_m = 1'b0;
        end else if (ones_m >= 2) begin
          busy_m = 1'b1; inv_m = 1'b1;
        end
      end else if (st_m[3:0] == 4'd0) begin
        busy_m = 1'b0; inv_m = 1'b0;
      end
      for (int b = 0; b < 5; b++) begin
        all_m = 1'b1;
        for (int j = 2; j <= N + 1; j++) if (hist[j][b] == st_m[b]) all_m = 1'b0;
        if (all_m) st_m[b] = ~st_m[b];
      end
    end
  end

  function automatic logic [12:0] exp_v();
    logic [1:0] e;
    e = busy_m ? (inv_m ? 2'd2 : 2'd1) : 2'd0;
    return {st_m[3:0], jp_m, pl_m, cod_m, busy_m & inv_m, e};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int pe;
    reset = 1'b0; botoes_in = 4'b0100; jogar_in = 1'b0;
    model_clear();
    repeat (3) tick();
    checks++;
    if (dut_v !== 13'd0) begin
      errors++; $display("FAIL reset_hold got=%h want=%h", dut_v, 13'd0);
    end
    reset = 1'b1;
    pe = -1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (jogada_pulso && pe < 0) pe = e;
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL reset_model cyc=%0d got=%h want=%h", e, dut_v, exp_v());
      end
    end
    checks++;
    if (pe !== 7 || jogada_codigo !== 4'b0100) begin
      errors++; $display("FAIL reset_latency edge=%0d code=%b want edge=7 code=0100", pe, jogada_codigo);
    end
  endtask

  task automatic test_bounce();
    int np;
    botoes_in = 4'd0;
    repeat (12) tick();
    for (int c = 0; c < 20; c++) begin
      botoes_in[0] = ((c / 2) % 2) == 0;
      tick();
      checks++;
      if (botoes_limpos[0] !== 1'b0 || jogada_pulso !== 1'b0 || dut_v !== exp_v()) begin
        errors++; $display("FAIL bounce cyc=%0d got=%h want=%h", c, dut_v, exp_v());
      end
    end
    botoes_in = 4'b0001;
    np = 0;
    repeat (12) begin
      tick();
      np += int'(jogada_pulso);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL bounce_hold got=%h want=%h", dut_v, exp_v());
      end
    end
    checks++;
    if (np !== 1 || jogada_codigo !== 4'b0001 || db_estado !== 2'd1) begin
      errors++; $display("FAIL bounce_accept pulses=%0d code=%b st=%0d want 1/0001/1", np, jogada_codigo, db_estado);
    end
  endtask

  task automatic test_hold_extra();
    int np;
    botoes_in = 4'd0;
    repeat (12) tick();
    botoes_in = 4'b0010;
    np = 0;
    for (int c = 0; c < 70; c++) begin
      if (c == 50) botoes_in = 4'b1010;
      tick();
      np += int'(jogada_pulso);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL hold_model cyc=%0d got=%h want=%h", c, dut_v, exp_v());
      end
    end
    checks++;
    if (np !== 1 || jogada_codigo !== 4'b0010) begin
      errors++; $display("FAIL hold_extra pulses=%0d code=%b want 1/0010", np, jogada_codigo);
    end
    botoes_in = 4'd0;
    repeat (15) tick();
    checks++;
    if (db_estado !== 2'd0) begin
      errors++; $display("FAIL hold_release st=%0d want 0", db_estado);
    end
  endtask

  task automatic test_simultaneous();
    int np;
    np = 0;
    botoes_in = 4'b0011;
    repeat (12) begin
      tick();
      np += int'(jogada_pulso);
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL simul_model got=%h want=%h", dut_v, exp_v());
      end
    end
    checks++;
    if (db_estado !== 2'd2 || multipla !== 1'b1 || np !== 0 || jogada_codigo !== 4'b0010) begin
      errors++; $display("FAIL simul st=%0d mul=%b pulses=%0d code=%b want 2/1/0/0010", db_estado, multipla, np, jogada_codigo);
    end
    botoes_in = 4'b0010;
    repeat (12) tick();
    checks++;
    if (multipla !== 1'b1 || db_estado !== 2'd2) begin
      errors++; $display("FAIL simul_partial mul=%b st=%0d want 1/2", multipla, db_estado);
    end
    botoes_in = 4'd0;
    repeat (12) tick();
    checks++;
    if (multipla !== 1'b0 || db_estado !== 2'd0) begin
      errors++; $display("FAIL simul_release mul=%b st=%0d want 0/0", multipla, db_estado);
    end
  endtask

  task automatic test_jogar();
    int n, pe, pj, pc;
    jogar_in = 1'b1;
    n = 0; pe = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (jogar_pulso) begin n++; if (pe < 0) pe = e; end
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL jogar_model cyc=%0d got=%h want=%h", e, dut_v, exp_v());
      end
    end
    checks++;
    if (n !== 1 || pe !== 7) begin
      errors++; $display("FAIL jogar_press pulses=%0d edge=%0d want 1/7", n, pe);
    end
    jogar_in = 1'b0;
    n = 0;
    repeat (15) begin tick(); n += int'(jogar_pulso); end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL jogar_release pulses=%0d want 0", n);
    end
    jogar_in = 1'b1; botoes_in = 4'b0100;
    pj = -1; pc = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (jogar_pulso && pj < 0) pj = e;
      if (jogada_pulso && pc < 0) pc = e;
    end
    checks++;
    if (pj !== 7 || pc !== 7 || jogada_codigo !== 4'b0100) begin
      errors++; $display("FAIL jogar_both jog=%0d play=%0d code=%b want 7/7/0100", pj, pc, jogada_codigo);
    end
    jogar_in = 1'b0; botoes_in = 4'd0;
    repeat (12) tick();
  endtask

  task automatic test_async_reset();
    int pe;
    botoes_in = 4'b1000;
    repeat (8) tick();
    botoes_in = 4'd0;
    repeat (10) tick();
    botoes_in = 4'b1000;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_v !== 13'd0) begin
      errors++; $display("FAIL async_clear got=%h want=%h", dut_v, 13'd0);
    end
    repeat (2) tick();
    reset = 1'b1;
    pe = -1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (jogada_pulso && pe < 0) pe = e;
      checks++;
      if (dut_v !== exp_v()) begin
        errors++; $display("FAIL async_model cyc=%0d got=%h want=%h", e, dut_v, exp_v());
      end
    end
    checks++;
    if (pe !== 7 || jogada_codigo !== 4'b1000) begin
      errors++; $display("FAIL async_latency edge=%0d code=%b want 7/1000", pe, jogada_codigo);
    end
  endtask

  task automatic test_random();
    logic [4:0] pat;
    int dur;
    for (int s = 0; s < 300; s++) begin
      pat = 5'($urandom);
      if ($urandom_range(0, 3) == 0) pat = 5'd0;
      botoes_in = pat[3:0];
      jogar_in = pat[4];
      dur = $urandom_range(1, 12);
      repeat (dur) begin
        tick();
        checks++;
        if (dut_v !== exp_v()) begin
          errors++; $display("FAIL random seg=%0d got=%h want=%h", s, dut_v, exp_v());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_hold_extra();
    test_simultaneous();
    test_jogar();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
